// File: rtl/fruit_catch_unit.sv
// Falling-fruit game core: spawns one fruit at an LFSR-chosen column, drops it one
// pixel every FALL_DIV cycles and scores a catch or a miss against the basket.
module fruit_catch_unit #(
  parameter int         SCREEN_WIDTH = 160,
  parameter int         BASKET_WIDTH = 15,
  parameter int         FRUIT_SIZE   = 4,
  parameter int         BASKET_Y     = 110,
  parameter int         FALL_DIV     = 833333,
  parameter int         MAX_MISSES   = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] X_basket,
  output logic [7:0] X_fruit,
  output logic [6:0] Y_fruit,
  output logic       fruit_valid,
  output logic       catch_pulse,
  output logic       miss_pulse,
  output logic [9:0] score,
  output logic [1:0] misses,
  output logic       game_over
);

  localparam int                TICK_W    = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FALL_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [7:0]        X_MAX     = 8'(SCREEN_WIDTH - FRUIT_SIZE);
  localparam logic [7:0]        Y_LAND    = 8'(BASKET_Y);
  localparam logic [7:0]        FS8       = 8'(FRUIT_SIZE);
  localparam logic [8:0]        FS9       = 9'(FRUIT_SIZE);
  localparam logic [8:0]        BW9       = 9'(BASKET_WIDTH);
  localparam logic [2:0]        MISS_END  = 3'(MAX_MISSES);
  localparam logic [9:0]        SCORE_MAX = 10'd999;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FALL,
    S_CHECK,
    S_OVER
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        x_reg, x_next;
  logic [6:0]        y_reg, y_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic              valid_reg, valid_next;
  logic              catch_reg, catch_next;
  logic              miss_reg, miss_next;
  logic [9:0]        score_reg, score_next;
  logic [1:0]        misses_reg, misses_next;
  logic              over_reg, over_next;
  logic [7:0]        lfsr_reg;

  logic              lfsr_fb;
  logic [6:0]        y_inc;
  logic              landed;
  logic              hit;
  logic [2:0]        miss_count;
  logic [7:0]        spawn_x;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_fb    = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign y_inc      = y_reg + 7'd1;
  assign landed     = ({1'b0, y_inc} + FS8) == Y_LAND;
  // 9-bit compare so basket/fruit right edges near 255 cannot wrap
  assign hit        = (({1'b0, x_reg} + FS9) > {1'b0, X_basket}) &&
                      ({1'b0, x_reg} < ({1'b0, X_basket} + BW9));
  assign miss_count = {1'b0, misses_reg} + 3'd1;
  assign spawn_x    = (lfsr_reg <= X_MAX) ? lfsr_reg : lfsr_reg - (X_MAX + 8'd1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= S_IDLE;
      x_reg      <= 8'd0;
      y_reg      <= 7'd0;
      tick_reg   <= '0;
      valid_reg  <= 1'b0;
      catch_reg  <= 1'b0;
      miss_reg   <= 1'b0;
      score_reg  <= 10'd0;
      misses_reg <= 2'd0;
      over_reg   <= 1'b0;
      lfsr_reg   <= LFSR_SEED;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      tick_reg   <= tick_next;
      valid_reg  <= valid_next;
      catch_reg  <= catch_next;
      miss_reg   <= miss_next;
      score_reg  <= score_next;
      misses_reg <= misses_next;
      over_reg   <= over_next;
      lfsr_reg   <= {lfsr_reg[6:0], lfsr_fb};
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    tick_next   = tick_reg;
    valid_next  = valid_reg;
    catch_next  = 1'b0;
    miss_next   = 1'b0;
    score_next  = score_reg;
    misses_next = misses_reg;
    over_next   = over_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          score_next  = 10'd0;
          misses_next = 2'd0;
          state_next  = S_SPAWN;
        end
      end
      S_SPAWN: begin
        x_next     = spawn_x;
        y_next     = 7'd0;
        tick_next  = '0;
        valid_next = 1'b1;
        state_next = S_FALL;
      end
      S_FALL: begin
        if (tick_reg == TICK_LAST) begin
          tick_next = '0;
          y_next    = y_inc;
          if (landed) begin
            state_next = S_CHECK;
          end
        end else begin
          tick_next = tick_reg + TICK_ONE;
        end
      end
      S_CHECK: begin
        if (hit) begin
          score_next = (score_reg == SCORE_MAX) ? score_reg : score_reg + 10'd1;
          catch_next = 1'b1;
          state_next = S_SPAWN;
        end else begin
          misses_next = misses_reg + 2'd1;
          miss_next   = 1'b1;
          if (miss_count == MISS_END) begin
            valid_next = 1'b0;
            over_next  = 1'b1;
            state_next = S_OVER;
          end else begin
            state_next = S_SPAWN;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          score_next  = 10'd0;
          misses_next = 2'd0;
          over_next   = 1'b0;
          state_next  = S_SPAWN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign X_fruit     = x_reg;
  assign Y_fruit     = y_reg;
  assign fruit_valid = valid_reg;
  assign catch_pulse = catch_reg;
  assign miss_pulse  = miss_reg;
  assign score       = score_reg;
  assign misses      = misses_reg;
  assign game_over   = over_reg;

endmodule

// File: tb/tb_fruit_catch_unit.sv
// Bench for fruit_catch_unit: one instance at full screen geometry (FALL_DIV=2) and a
// short-drop instance used for bulk spawn-range and score-saturation runs.
`timescale 1ns/1ps
module tb_fruit_catch_unit;

  localparam int FALL_DIV     = 2;
  localparam int SCREEN_WIDTH = 160;
  localparam int FRUIT_SIZE   = 4;
  localparam int BASKET_WIDTH = 15;
  localparam int BASKET_Y     = 110;
  localparam int X_MAX        = SCREEN_WIDTH - FRUIT_SIZE;
  localparam int LAND_Y       = BASKET_Y - FRUIT_SIZE;
  localparam int LAT          = 1 + LAND_Y * FALL_DIV;

  logic       Clock = 1'b0;
  logic       Reset, start, Reset2, start2;
  logic [7:0] X_basket, X_basket2;
  logic [7:0] X_fruit, X_fruit2;
  logic [6:0] Y_fruit, Y_fruit2;
  logic       fruit_valid, catch_pulse, miss_pulse, game_over;
  logic       fruit_valid2, catch_pulse2, miss_pulse2, game_over2;
  logic [9:0] score, score2;
  logic [1:0] misses, misses2;

  int checks = 0;
  int errors = 0;
  int m_score, m_misses, m2_score, m2_misses;

  fruit_catch_unit #(.FALL_DIV(FALL_DIV)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .X_basket(X_basket),
    .X_fruit(X_fruit), .Y_fruit(Y_fruit), .fruit_valid(fruit_valid),
    .catch_pulse(catch_pulse), .miss_pulse(miss_pulse), .score(score),
    .misses(misses), .game_over(game_over)
  );

  fruit_catch_unit #(.BASKET_Y(FRUIT_SIZE + 1), .FALL_DIV(1)) dut2 (
    .Clock(Clock), .Reset(Reset2), .start(start2), .X_basket(X_basket2),
    .X_fruit(X_fruit2), .Y_fruit(Y_fruit2), .fruit_valid(fruit_valid2),
    .catch_pulse(catch_pulse2), .miss_pulse(miss_pulse2), .score(score2),
    .misses(misses2), .game_over(game_over2)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Two half-open intervals [xf, xf+size) and [xb, xb+width) overlap
  function automatic bit overlap(input int xf, input int xb);
    int lo, hi;
    lo = (xf > xb) ? xf : xb;
    hi = ((xf + FRUIT_SIZE) < (xb + BASKET_WIDTH)) ? (xf + FRUIT_SIZE) : (xb + BASKET_WIDTH);
    return lo < hi;
  endfunction

  function automatic int sat_inc(input int s);
    return (s < 999) ? s + 1 : 999;
  endfunction

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_score  = 0;
    m_misses = 0;
  endtask

  // Leaves the bench in the first FALL cycle of the new game's first fruit
  task automatic start_game(input string name);
    start = 1'b1;
    step();
    start = 1'b0;
    m_score  = 0;
    m_misses = 0;
    checks++;
    if (score !== 10'd0 || misses !== 2'd0 || game_over !== 1'b0 || fruit_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear: score=%0d misses=%0d game_over=%0d valid=%0d, expected 0 0 0 0",
               name, score, misses, game_over, fruit_valid);
    end
    step();
    checks++;
    if (fruit_valid !== 1'b1 || Y_fruit !== 7'd0 || $isunknown(X_fruit) || X_fruit > 8'(X_MAX)) begin
      errors++;
      $display("FAIL %s_spawn: valid=%0d Y=%0d X=%0d, expected valid=1 Y=0 X<=%0d",
               name, fruit_valid, Y_fruit, X_fruit, X_MAX);
    end
    $display("%s: game started, fruit at X=%0d", name, X_fruit);
  endtask

  // mode 0 catch, 1 right-edge touch, 2 left-edge touch, 3 random basket, 4 basket held at 0
  task automatic fall_and_check(input int mode);
    logic [7:0] xf, want;
    bit exp_catch, seen, over;
    int k;
    xf = X_fruit;
    case (mode)
      0:       want = (xf >= 8'd5) ? xf - 8'd5 : 8'd0;
      1:       want = xf + 8'(FRUIT_SIZE);
      2:       want = (xf >= 8'(BASKET_WIDTH)) ? xf - 8'(BASKET_WIDTH) : xf + 8'(FRUIT_SIZE);
      3:       want = 8'($urandom_range(0, 255));
      default: want = 8'd0;
    endcase
    exp_catch = overlap(int'(xf), int'(want));
    k    = 0;
    seen = 1'b0;
    while (!seen && k < LAT + 20) begin
      if (mode == 4 || k >= LAT - 3) X_basket = want;
      else X_basket = 8'($urandom_range(0, 255));
      step();
      k++;
      seen = (catch_pulse === 1'b1) || (miss_pulse === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL latency: no pulse within %0d cycles, expected one after %0d", k, LAT);
      return;
    end
    if (k != LAT) begin
      errors++;
      $display("FAIL latency: pulse after %0d cycles, expected %0d", k, LAT);
    end
    checks++;
    if (catch_pulse !== exp_catch || miss_pulse !== !exp_catch) begin
      errors++;
      $display("FAIL verdict: X_fruit=%0d X_basket=%0d catch=%0d miss=%0d, expected catch=%0d",
               xf, want, catch_pulse, miss_pulse, exp_catch);
    end
    checks++;
    if (X_fruit !== xf || Y_fruit !== 7'(LAND_Y)) begin
      errors++;
      $display("FAIL position: X=%0d Y=%0d, expected X=%0d Y=%0d", X_fruit, Y_fruit, xf, LAND_Y);
    end
    if (exp_catch) m_score = sat_inc(m_score);
    else m_misses++;
    over = (m_misses >= 3);
    checks++;
    if (score !== 10'(m_score) || misses !== 2'(m_misses)) begin
      errors++;
      $display("FAIL tally: score=%0d misses=%0d, expected %0d %0d", score, misses, m_score, m_misses);
    end
    checks++;
    if (game_over !== over || fruit_valid !== !over) begin
      errors++;
      $display("FAIL over_flag: game_over=%0d valid=%0d, expected %0d %0d", game_over, fruit_valid, over, !over);
    end
    step();
    checks++;
    if (catch_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: catch=%0d miss=%0d one cycle later, expected 0 0", catch_pulse, miss_pulse);
    end
    checks++;
    if (!over) begin
      if (fruit_valid !== 1'b1 || Y_fruit !== 7'd0 || $isunknown(X_fruit) || X_fruit > 8'(X_MAX)) begin
        errors++;
        $display("FAIL respawn: valid=%0d Y=%0d X=%0d, expected valid=1 Y=0 X<=%0d",
                 fruit_valid, Y_fruit, X_fruit, X_MAX);
      end
    end else if (game_over !== 1'b1 || fruit_valid !== 1'b0 || misses !== 2'd3) begin
      errors++;
      $display("FAIL over_hold: game_over=%0d valid=%0d misses=%0d, expected 1 0 3", game_over, fruit_valid, misses);
    end
    $display("fruit X=%0d basket=%0d -> %s score=%0d misses=%0d", xf, want,
             exp_catch ? "catch" : "miss", m_score, m_misses);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    start = 1'b1;
    step();
    checks++;
    if ({X_fruit, Y_fruit, fruit_valid, catch_pulse, miss_pulse, score, misses, game_over} !== 31'd0) begin
      errors++;
      $display("FAIL reset: X=%0d Y=%0d valid=%0d catch=%0d miss=%0d score=%0d misses=%0d over=%0d, expected all 0",
               X_fruit, Y_fruit, fruit_valid, catch_pulse, miss_pulse, score, misses, game_over);
    end
    Reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fruit_valid !== 1'b0 || Y_fruit !== 7'd0 || score !== 10'd0 || game_over !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: valid=%0d Y=%0d score=%0d over=%0d, expected 0 0 0 0",
                 fruit_valid, Y_fruit, score, game_over);
      end
    end
    m_score  = 0;
    m_misses = 0;
    $display("test_reset: done");
  endtask

  task automatic test_first_fruit();
    X_basket = 8'd0;
    start_game("first");
    fall_and_check(4);
  endtask

  task automatic test_catch();
    fall_and_check(0);
    fall_and_check(0);
  endtask

  task automatic test_edge_miss();
    pulse_reset();
    start_game("edge");
    fall_and_check(1);
    fall_and_check(2);
  endtask

  task automatic test_game_over();
    pulse_reset();
    start_game("over");
    fall_and_check(1);
    fall_and_check(1);
    fall_and_check(1);
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (game_over !== 1'b1 || fruit_valid !== 1'b0 || misses !== 2'd3 || score !== 10'(m_score) ||
          catch_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
        errors++;
        $display("FAIL over_idle: over=%0d valid=%0d misses=%0d score=%0d pulses=%0d%0d, expected 1 0 3 %0d 00",
                 game_over, fruit_valid, misses, score, catch_pulse, miss_pulse, m_score);
      end
    end
    start_game("restart");
  endtask

  task automatic test_start_held();
    start = 1'b1;
    fall_and_check(0);
    fall_and_check(0);
    checks++;
    if (score !== 10'd2) begin
      errors++;
      $display("FAIL start_held: score=%0d, expected 2", score);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_fall();
    int guard;
    guard = 0;
    while (Y_fruit !== 7'd50 && guard < 300) begin
      step();
      guard++;
    end
    checks++;
    if (Y_fruit !== 7'd50) begin
      errors++;
      $display("FAIL reach_y50: Y=%0d after %0d cycles, expected 50", Y_fruit, guard);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_score  = 0;
    m_misses = 0;
    checks++;
    if ({X_fruit, Y_fruit, fruit_valid, catch_pulse, miss_pulse, score, misses, game_over} !== 31'd0) begin
      errors++;
      $display("FAIL mid_fall_reset: X=%0d Y=%0d valid=%0d catch=%0d miss=%0d score=%0d misses=%0d over=%0d, expected all 0",
               X_fruit, Y_fruit, fruit_valid, catch_pulse, miss_pulse, score, misses, game_over);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (catch_pulse !== 1'b0 || miss_pulse !== 1'b0 || fruit_valid !== 1'b0) begin
        errors++;
        $display("FAIL after_reset: catch=%0d miss=%0d valid=%0d, expected 0 0 0", catch_pulse, miss_pulse, fruit_valid);
      end
    end
    $display("test_reset_mid_fall: done");
  endtask

  // Short-drop instance: plays n fruits, restarting after each game over
  task automatic run_dut2(input int n_fruits, input bit always_catch);
    int fruits, guard;
    bit exp_catch;
    logic [7:0] xb;
    fruits    = 0;
    guard     = 0;
    exp_catch = 1'b0;
    while (fruits < n_fruits && guard < 20000) begin
      if (fruit_valid2 === 1'b1 && Y_fruit2 === 7'd0) begin
        checks++;
        if ($isunknown(X_fruit2) || X_fruit2 > 8'(X_MAX)) begin
          errors++;
          $display("FAIL spawn_range: X_fruit=%0d, expected <= %0d", X_fruit2, X_MAX);
        end
        xb = always_catch ? X_fruit2 : 8'($urandom_range(0, 255));
        X_basket2 = xb;
        exp_catch = overlap(int'(X_fruit2), int'(xb));
      end
      if (catch_pulse2 === 1'b1 || miss_pulse2 === 1'b1) begin
        fruits++;
        checks++;
        if (catch_pulse2 !== exp_catch || miss_pulse2 !== !exp_catch) begin
          errors++;
          $display("FAIL bulk_verdict: catch=%0d miss=%0d, expected catch=%0d", catch_pulse2, miss_pulse2, exp_catch);
        end
        if (exp_catch) m2_score = sat_inc(m2_score);
        else m2_misses++;
        checks++;
        if (score2 !== 10'(m2_score) || misses2 !== 2'(m2_misses) || game_over2 !== (m2_misses >= 3)) begin
          errors++;
          $display("FAIL bulk_tally: score=%0d misses=%0d over=%0d, expected %0d %0d %0d",
                   score2, misses2, game_over2, m2_score, m2_misses, (m2_misses >= 3));
        end
        if (m2_misses >= 3) begin
          repeat ($urandom_range(0, 5)) step();
          start2 = 1'b1;
          step();
          start2    = 1'b0;
          m2_score  = 0;
          m2_misses = 0;
          checks++;
          if (score2 !== 10'd0 || misses2 !== 2'd0 || game_over2 !== 1'b0) begin
            errors++;
            $display("FAIL bulk_restart: score=%0d misses=%0d over=%0d, expected 0 0 0", score2, misses2, game_over2);
          end
        end
      end
      step();
      guard++;
    end
    checks++;
    if (fruits < n_fruits) begin
      errors++;
      $display("FAIL bulk_timeout: %0d fruits resolved, expected %0d", fruits, n_fruits);
    end
  endtask

  task automatic test_range_and_saturation();
    Reset2 = 1'b0;
    start2 = 1'b1;
    step();
    start2    = 1'b0;
    m2_score  = 0;
    m2_misses = 0;
    run_dut2(1000, 1'b0);
    $display("test_range: 1000 random fruits resolved");
    Reset2 = 1'b1;
    step();
    Reset2 = 1'b0;
    start2 = 1'b1;
    step();
    start2    = 1'b0;
    m2_score  = 0;
    m2_misses = 0;
    run_dut2(1001, 1'b1);
    checks++;
    if (score2 !== 10'd999) begin
      errors++;
      $display("FAIL saturate: score=%0d after 1001 catches, expected 999", score2);
    end
    $display("test_saturation: score=%0d", score2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    start     = 1'b0;
    X_basket  = 8'd0;
    Reset2    = 1'b1;
    start2    = 1'b0;
    X_basket2 = 8'd0;
    step();
    step();
    test_reset();
    test_first_fruit();
    test_catch();
    test_edge_miss();
    test_game_over();
    test_start_held();
    test_reset_mid_fall();
    test_range_and_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
